// File: rtl/slugtpu_pkg.sv
// Shared definitions for the slugtpu activation path: default widths,
// requester-id type and the arbiter FSM state encoding.
package slugtpu_pkg;

  localparam int NUM_REQ_DEFAULT = 4;
  localparam int DATA_W_DEFAULT  = 32;
  localparam int REQ_ID_W        = $clog2(NUM_REQ_DEFAULT);

  // Identifies which requester produced a beat (sized for the default requester count).
  typedef logic [REQ_ID_W-1:0] req_id_t;

  // Arbiter is either choosing a requester or serving one.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Circular first-set search starting at ptr_i; returns one-hot and index.
module rr_arbiter #(
  parameter int N  = slugtpu_pkg::NUM_REQ_DEFAULT,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_oh_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_any_o
);

  logic [IW:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester at/after ptr wins.
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    cand      = '0;
    for (int off = N - 1; off >= 0; off--) begin
      cand = {1'b0, ptr_i} + (IW+1)'(off);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      if (req_i[cand[IW-1:0]]) begin
        gnt_oh_o                 = '0;
        gnt_oh_o[cand[IW-1:0]]   = 1'b1;
        gnt_idx_o                = cand[IW-1:0];
        gnt_any_o                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/act_arbiter.sv
// Round-robin burst arbiter feeding a one-stage ReLU/pass-through output register.
module act_arbiter
  import slugtpu_pkg::*;
#(
  parameter int NUM_REQ      = NUM_REQ_DEFAULT,
  parameter int DATA_W       = DATA_W_DEFAULT,
  parameter int BURST_LEN    = 8,
  parameter int IDLE_TIMEOUT = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              cfg_relu_en_i,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]    req_data_i,
  input  logic [NUM_REQ-1:0]                req_last_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  output logic                              out_valid_o,
  output logic [DATA_W-1:0]                 out_data_o,
  output logic [$clog2(NUM_REQ)-1:0]        out_id_o,
  output logic                              out_last_o,
  input  logic                              out_ready_i,
  output logic                              busy_o
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int BC_W = $clog2(BURST_LEN + 1);
  localparam int IC_W = $clog2(IDLE_TIMEOUT + 1);

  arb_state_e         state_q, state_d;
  logic [ID_W-1:0]    gnt_q, gnt_d;
  logic [NUM_REQ-1:0] gnt_oh_q, gnt_oh_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [BC_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [IC_W-1:0]    idle_cnt_q, idle_cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [ID_W-1:0]    out_id_q, out_id_d;
  logic               out_last_q, out_last_d;

  logic [NUM_REQ-1:0] arb_oh;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_any;

  logic               slot_free;
  logic               sel_valid;
  logic               sel_last;
  logic [DATA_W-1:0]  sel_data;
  logic               accept;
  logic               burst_end;
  logic [BC_W-1:0]    beat_inc;
  logic [IC_W-1:0]    idle_inc;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_rr_arbiter (
    .req_i     (req_valid_i),
    .ptr_i     (rr_ptr_q),
    .gnt_oh_o  (arb_oh),
    .gnt_idx_o (arb_idx),
    .gnt_any_o (arb_any)
  );

  // The output register can take a new beat if empty or being drained this cycle.
  assign slot_free = !out_valid_q || out_ready_i;
  assign sel_valid = req_valid_i[gnt_q];
  assign sel_last  = req_last_i[gnt_q];
  assign sel_data  = req_data_i[gnt_q];
  assign accept    = (state_q == ST_BURST) && sel_valid && slot_free;
  assign beat_inc  = beat_cnt_q + BC_W'(1);
  assign idle_inc  = idle_cnt_q + IC_W'(1);

  // Only the granted requester sees ready, and only while bursting.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready_o[gi] = (state_q == ST_BURST) && slot_free && gnt_oh_q[gi];
  end

  // Arbitration FSM: grant in IDLE, count beats and idle cycles in BURST.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_oh_d   = gnt_oh_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    idle_cnt_d = idle_cnt_q;
    burst_end  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          gnt_d      = arb_idx;
          gnt_oh_d   = arb_oh;
          beat_cnt_d = '0;
          idle_cnt_d = '0;
          state_d    = ST_BURST;
        end
      end
      ST_BURST: begin
        // A stalled downstream is not the requester's fault, so it does not age the grant.
        if (sel_valid) begin
          idle_cnt_d = '0;
        end else if (out_ready_i) begin
          idle_cnt_d = idle_inc;
          if (idle_inc == IC_W'(IDLE_TIMEOUT)) begin
            burst_end = 1'b1;
          end
        end
        if (accept) begin
          beat_cnt_d = beat_inc;
          if (sel_last || (beat_inc == BC_W'(BURST_LEN))) begin
            burst_end = 1'b1;
          end
        end
        if (burst_end) begin
          state_d  = ST_IDLE;
          rr_ptr_d = (gnt_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_q + ID_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output stage: load an accepted beat, hold under backpressure, drop when drained.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_last_d  = out_last_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = (cfg_relu_en_i && sel_data[DATA_W-1]) ? '0 : sel_data;
      out_id_d    = gnt_q;
      out_last_d  = sel_last;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      gnt_oh_q    <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_oh_q    <= gnt_oh_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_id_o    = out_id_q;
  assign out_last_o  = out_last_q;
  assign busy_o      = (state_q == ST_BURST);

endmodule
